// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line, configuration and result signals of uart_rx
interface uart_rx_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic                      RX_IN;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      Data_Valid;
    logic                      Parity_Error;
    logic                      Stop_Error;
    logic                      busy;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  P_DATA, Data_Valid, Parity_Error, Stop_Error, busy
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output P_DATA, Data_Valid, Parity_Error, Stop_Error, busy
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with majority vote, parity and stop checks
module uart_rx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic       CLK,
    input  logic       RST,
    uart_rx_if.slave   bus
);
    localparam int BW = $clog2(DATA_WIDTH + 3);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] edge_q, edge_d;
    logic [BW-1:0]             bit_q, bit_d;
    logic [1:0]                ones_q, ones_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic [DATA_WIDTH-1:0]     pdata_q, pdata_d;
    logic                      pen_q, pen_d, ptyp_q, ptyp_d;
    logic                      perr_q, perr_d;
    logic                      dv_q, dv_d, pe_q, pe_d, se_q, se_d;

    logic [PRESCALE_WIDTH-1:0] half;
    logic                      last, sample_hit, bit_val;

    assign half       = bus.Prescale >> 1;
    assign last       = (edge_q == bus.Prescale - PRESCALE_WIDTH'(1));
    assign sample_hit = (edge_q == half - PRESCALE_WIDTH'(1)) || (edge_q == half) ||
                        (edge_q == half + PRESCALE_WIDTH'(1));
    // all three votes land before the window's last edge, so ones_q is final there
    assign bit_val    = ones_q[1];

    always_comb begin
        state_d = state_q;
        edge_d  = edge_q;
        bit_d   = bit_q;
        ones_d  = ones_q;
        shift_d = shift_q;
        pdata_d = pdata_q;
        pen_d   = pen_q;
        ptyp_d  = ptyp_q;
        perr_d  = perr_q;
        dv_d    = 1'b0;
        pe_d    = 1'b0;
        se_d    = 1'b0;
        if (state_q == IDLE) begin
            if (!bus.RX_IN) begin
                // the detecting cycle itself counts as edge 0 of the start bit
                state_d = START;
                edge_d  = PRESCALE_WIDTH'(1);
                bit_d   = '0;
                ones_d  = '0;
                pen_d   = bus.PAR_EN;
                ptyp_d  = bus.PAR_TYP;
                perr_d  = 1'b0;
            end
        end else begin
            edge_d = last ? '0 : edge_q + PRESCALE_WIDTH'(1);
            ones_d = last ? 2'd0 : ones_q + {1'b0, sample_hit & bus.RX_IN};
            if (last) begin
                bit_d = bit_q + BW'(1);
                case (state_q)
                    START:   state_d = bit_val ? IDLE : DATA;
                    DATA: begin
                        shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
                        if (bit_q == BW'(DATA_WIDTH))
                            state_d = pen_q ? PARITY : STOP;
                    end
                    PARITY: begin
                        perr_d  = bit_val != ((^shift_q) ^ ptyp_q);
                        state_d = STOP;
                    end
                    STOP: begin
                        state_d = IDLE;
                        pe_d    = perr_q;
                        se_d    = ~bit_val;
                        dv_d    = ~perr_q & bit_val;
                        if (~perr_q & bit_val)
                            pdata_d = shift_q;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            edge_q  <= '0;
            bit_q   <= '0;
            ones_q  <= '0;
            shift_q <= '0;
            pdata_q <= '0;
            pen_q   <= 1'b0;
            ptyp_q  <= 1'b0;
            perr_q  <= 1'b0;
            dv_q    <= 1'b0;
            pe_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            bit_q   <= bit_d;
            ones_q  <= ones_d;
            shift_q <= shift_d;
            pdata_q <= pdata_d;
            pen_q   <= pen_d;
            ptyp_q  <= ptyp_d;
            perr_q  <= perr_d;
            dv_q    <= dv_d;
            pe_q    <= pe_d;
            se_q    <= se_d;
        end
    end

    assign bus.P_DATA       = pdata_q;
    assign bus.Data_Valid   = dv_q;
    assign bus.Parity_Error = pe_q;
    assign bus.Stop_Error   = se_q;
    // busy covers the detecting cycle t0, which is still spent in IDLE
    assign bus.busy         = RST & ((state_q != IDLE) | ~bus.RX_IN);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - table-driven self-checking bench for uart_rx
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    uart_rx_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) bus ();

    uart_rx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] pdata;
    } ev_t;

    ev_t  ev_q[$];
    logic busy_prev = 1'b0;
    int   busy_fall = -1;

    always @(negedge clk) begin
        if (bus.Data_Valid || bus.Parity_Error || bus.Stop_Error)
            ev_q.push_back('{cyc, bus.Data_Valid, bus.Parity_Error, bus.Stop_Error, bus.P_DATA});
        if (busy_prev && !bus.busy)
            busy_fall = cyc;
        busy_prev = bus.busy;
    end

    typedef struct {
        int         presc;
        logic       pen;
        logic       ptyp;
        logic [7:0] data;
        logic       pbit;
        logic       sbit;
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] pdata;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int p);
        bus.RX_IN = b;
        repeat (p) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.RX_IN = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // called 1 time unit after a rising edge; returns cycle t0 and busy seen in t0
    task automatic send_frame(input int p, input logic pen, input logic ptyp, input logic [7:0] d,
                              input logic pbit, input logic sbit, output int t0, output logic b0);
        bus.Prescale = 6'(p);
        bus.PAR_EN   = pen;
        bus.PAR_TYP  = ptyp;
        t0           = cyc;
        bus.RX_IN    = 1'b0;
        @(negedge clk);
        b0 = bus.busy;
        repeat (p) @(posedge clk);
        #1;
        bus.PAR_EN  = ~pen;
        bus.PAR_TYP = ~ptyp;
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pen) drive_bit(pbit, p);
        drive_bit(sbit, p);
    endtask

    int   t0, t1, n;
    logic b0;

    initial begin
        bus.RX_IN    = 1'b1;
        bus.Prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;

        vecs[0] = '{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{16, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[2] = '{16, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
        vecs[3] = '{8,  1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
        vecs[4] = '{8,  1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A};
        vecs[5] = '{16, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h07};
        vecs[6] = '{32, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h07};
        vecs[7] = '{32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF};

        repeat (3) @(posedge clk);
        #1;
        bus.RX_IN = 1'b0;
        @(negedge clk);
        check("rst_busy_rx_low", {31'd0, bus.busy}, 32'd0);
        check("rst_outputs", {20'd0, bus.P_DATA, bus.Data_Valid, bus.Parity_Error, bus.Stop_Error, bus.busy}, 32'd0);
        @(posedge clk);
        #1;
        bus.RX_IN = 1'b1;
        rst_n     = 1'b1;
        idle(3);

        for (int i = 0; i < 8; i++) begin
            ev_q.delete();
            n = vecs[i].pen ? 11 : 10;
            send_frame(vecs[i].presc, vecs[i].pen, vecs[i].ptyp, vecs[i].data,
                       vecs[i].pbit, vecs[i].sbit, t0, b0);
            idle(5);
            check($sformatf("v%0d_busy_t0", i), {31'd0, b0}, 32'd1);
            check($sformatf("v%0d_busy_fall", i), busy_fall, t0 + n * vecs[i].presc);
            check($sformatf("v%0d_nevents", i), ev_q.size(), 32'd1);
            if (ev_q.size() > 0) begin
                check($sformatf("v%0d_ev_cycle", i), ev_q[0].c, t0 + n * vecs[i].presc);
                check($sformatf("v%0d_dv", i), {31'd0, ev_q[0].dv}, {31'd0, vecs[i].dv});
                check($sformatf("v%0d_pe", i), {31'd0, ev_q[0].pe}, {31'd0, vecs[i].pe});
                check($sformatf("v%0d_se", i), {31'd0, ev_q[0].se}, {31'd0, vecs[i].se});
            end
            check($sformatf("v%0d_pdata", i), {24'd0, bus.P_DATA}, {24'd0, vecs[i].pdata});
        end

        // short start glitch at Prescale 32, then a real frame
        ev_q.delete();
        bus.Prescale = 6'd32;
        t0 = cyc;
        bus.RX_IN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(40);
        check("glitch_nevents", ev_q.size(), 32'd0);
        check("glitch_busy_fall", busy_fall, t0 + 32);
        send_frame(32, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, t0, b0);
        idle(3);
        check("after_glitch_nevents", ev_q.size(), 32'd1);
        if (ev_q.size() > 0) begin
            check("after_glitch_cycle", ev_q[0].c, t0 + 320);
            check("after_glitch_dv", {31'd0, ev_q[0].dv}, 32'd1);
        end
        check("after_glitch_pdata", {24'd0, bus.P_DATA}, 32'h81);

        // back-to-back frames with no idle gap
        ev_q.delete();
        send_frame(8, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, t0, b0);
        send_frame(8, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1, t1, b0);
        idle(3);
        check("b2b_start_gap", t1 - t0, 32'd80);
        check("b2b_nevents", ev_q.size(), 32'd2);
        if (ev_q.size() == 2) begin
            check("b2b_ev0_cycle", ev_q[0].c, t0 + 80);
            check("b2b_ev_spacing", ev_q[1].c - ev_q[0].c, 32'd80);
            check("b2b_ev0_data", {24'd0, ev_q[0].pdata}, 32'h01);
            check("b2b_ev1_data", {24'd0, ev_q[1].pdata}, 32'hFE);
            check("b2b_ev1_dv", {31'd0, ev_q[1].dv}, 32'd1);
        end

        // reset asserted during data bit 4
        ev_q.delete();
        bus.Prescale = 6'd8;
        drive_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b1 : 1'b1, 8);
        bus.RX_IN = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {20'd0, bus.P_DATA, bus.Data_Valid, bus.Parity_Error, bus.Stop_Error, bus.busy}, 32'd0);
        @(posedge clk);
        #1;
        bus.RX_IN = 1'b1;
        rst_n     = 1'b1;
        idle(4);
        send_frame(8, 1'b0, 1'b0, 8'h77, 1'b0, 1'b1, t0, b0);
        idle(3);
        check("post_rst_nevents", ev_q.size(), 32'd1);
        if (ev_q.size() > 0) begin
            check("post_rst_cycle", ev_q[0].c, t0 + 80);
            check("post_rst_dv", {31'd0, ev_q[0].dv}, 32'd1);
        end
        check("post_rst_pdata", {24'd0, bus.P_DATA}, 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
